mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM pipeline stage; issues data-memory requests with lane
//            formatting and load extraction.
//            Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        IValid,
   input  logic [31:0] IALUOut,
   input  logic [31:0] IWriteData,
   input  logic [4:0]  IWriteReg,
   input  logic        ICRegWrite,
   input  logic [1:0]  ICMemtoReg,
   input  logic        ICMemRead,
   input  logic        ICMemWrite,
   input  logic [1:0]  ICMemSize,
   input  logic        ICMemSigned,
   output logic        OBusReq,
   output logic        OBusWe,
   output logic [31:0] OBusAddr,
   output logic [31:0] OBusWData,
   output logic [3:0]  OBusBe,
   input  logic [31:0] IBusRData,
   input  logic        IBusReady,
   output logic        OStall,
   output logic        OValid,
   output logic [31:0] OMemData,
   output logic [31:0] OALUOut,
   output logic [4:0]  OWriteReg,
   output logic        OCRegWrite,
   output logic [1:0]  OCMemtoReg,
   output logic        OMisalign
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01
   } state_t;

   state_t      state_q;
   logic        valid_q, regwrite_q, misalign_q;
   logic [31:0] memdata_q, aluout_q;
   logic [4:0]  wreg_q;
   logic [1:0]  memtoreg_q;
   logic [31:0] bus_wdata_q;
   logic [3:0]  bus_be_q;

   // Transaction context captured when entering WAIT
   logic [31:0] l_alu_q;
   logic        l_we_q, l_sgn_q, l_regwrite_q;
   logic [1:0]  l_size_q, l_memtoreg_q;
   logic [4:0]  l_wreg_q;

   logic        w_mem_req, w_misalign;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_ldata, w_shift;
   logic [15:0] w_half;

   assign w_mem_req = IValid & (ICMemRead | ICMemWrite);

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_misalign = w_mem_req &
                       (((ICMemSize == 2'b01) & IALUOut[0]) |
                        (((ICMemSize == 2'b00) | (ICMemSize == 2'b11)) & (IALUOut[1:0] != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = IWriteData;
      case (ICMemSize)
         2'b01: begin
            w_be    = IALUOut[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{IWriteData[15:0]}};
         end
         2'b10: begin
            w_be    = 4'b0001 << IALUOut[1:0];
            w_wdata = {4{IWriteData[7:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_ldata = IBusRData;
      w_half  = l_alu_q[1] ? IBusRData[31:16] : IBusRData[15:0];
      w_shift = IBusRData >> {l_alu_q[1:0], 3'b000};
      case (l_size_q)
         2'b01:   w_ldata = {{16{l_sgn_q & w_half[15]}}, w_half};
         2'b10:   w_ldata = {{24{l_sgn_q & w_shift[7]}}, w_shift[7:0]};
         default: ;
      endcase
   end

   always_comb begin
      OStall = 1'b0;
      case (state_q)
         S_IDLE:  OStall = w_mem_req & ~w_misalign;
         S_WAIT:  OStall = ~IBusReady;
         default: OStall = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         valid_q      <= 1'b0;
         regwrite_q   <= 1'b0;
         misalign_q   <= 1'b0;
         memdata_q    <= '0;
         aluout_q     <= '0;
         wreg_q       <= '0;
         memtoreg_q   <= '0;
         bus_wdata_q  <= '0;
         bus_be_q     <= '0;
         l_alu_q      <= '0;
         l_we_q       <= 1'b0;
         l_sgn_q      <= 1'b0;
         l_regwrite_q <= 1'b0;
         l_size_q     <= '0;
         l_memtoreg_q <= '0;
         l_wreg_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               valid_q    <= 1'b0;
               regwrite_q <= 1'b0;
               misalign_q <= 1'b0;
               if (IValid) begin
                  if (w_misalign) begin
                     valid_q    <= 1'b1;
                     misalign_q <= 1'b1;
                     memdata_q  <= '0;
                     aluout_q   <= IALUOut;
                     wreg_q     <= IWriteReg;
                     memtoreg_q <= ICMemtoReg;
                  end else if (w_mem_req) begin
                     state_q      <= S_WAIT;
                     bus_wdata_q  <= w_wdata;
                     bus_be_q     <= w_be;
                     l_alu_q      <= IALUOut;
                     l_we_q       <= ICMemWrite;
                     l_sgn_q      <= ICMemSigned;
                     l_size_q     <= ICMemSize;
                     l_regwrite_q <= ICRegWrite;
                     l_memtoreg_q <= ICMemtoReg;
                     l_wreg_q     <= IWriteReg;
                  end else begin
                     valid_q    <= 1'b1;
                     regwrite_q <= ICRegWrite;
                     memdata_q  <= '0;
                     aluout_q   <= IALUOut;
                     wreg_q     <= IWriteReg;
                     memtoreg_q <= ICMemtoReg;
                  end
               end
            end
            S_WAIT: begin
               if (IBusReady) begin
                  state_q    <= S_IDLE;
                  valid_q    <= 1'b1;
                  regwrite_q <= l_regwrite_q;
                  memdata_q  <= l_we_q ? 32'd0 : w_ldata;
                  aluout_q   <= l_alu_q;
                  wreg_q     <= l_wreg_q;
                  memtoreg_q <= l_memtoreg_q;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               valid_q    <= 1'b0;
               regwrite_q <= 1'b0;
            end
         endcase
      end
   end

   assign OBusReq    = (state_q == S_WAIT);
   assign OBusWe     = l_we_q;
   assign OBusAddr   = {l_alu_q[31:2], 2'b00};
   assign OBusWData  = bus_wdata_q;
   assign OBusBe     = bus_be_q;
   assign OValid     = valid_q;
   assign OMemData   = memdata_q;
   assign OALUOut    = aluout_q;
   assign OWriteReg  = wreg_q;
   assign OCRegWrite = regwrite_q;
   assign OCMemtoReg = memtoreg_q;
   assign OMisalign  = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench for mem_access_unit with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        IValid;
   logic [31:0] IALUOut, IWriteData, IBusRData;
   logic [4:0]  IWriteReg;
   logic        ICRegWrite, ICMemRead, ICMemWrite, ICMemSigned, IBusReady;
   logic [1:0]  ICMemtoReg, ICMemSize;
   logic        OBusReq, OBusWe, OStall, OValid, OCRegWrite, OMisalign;
   logic [31:0] OBusAddr, OBusWData, OMemData, OALUOut;
   logic [3:0]  OBusBe;
   logic [4:0]  OWriteReg;
   logic [1:0]  OCMemtoReg;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] alu;
      logic [4:0]  wreg;
      logic        rw;
      logic [1:0]  m2r;
      logic        mis;
   } exp_t;

   exp_t sb[$];

   mem_access_unit dut (
      .clk(clk), .reset(reset), .IValid(IValid), .IALUOut(IALUOut),
      .IWriteData(IWriteData), .IWriteReg(IWriteReg), .ICRegWrite(ICRegWrite),
      .ICMemtoReg(ICMemtoReg), .ICMemRead(ICMemRead), .ICMemWrite(ICMemWrite),
      .ICMemSize(ICMemSize), .ICMemSigned(ICMemSigned), .OBusReq(OBusReq),
      .OBusWe(OBusWe), .OBusAddr(OBusAddr), .OBusWData(OBusWData), .OBusBe(OBusBe),
      .IBusRData(IBusRData), .IBusReady(IBusReady), .OStall(OStall),
      .OValid(OValid), .OMemData(OMemData), .OALUOut(OALUOut),
      .OWriteReg(OWriteReg), .OCRegWrite(OCRegWrite), .OCMemtoReg(OCMemtoReg),
      .OMisalign(OMisalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every OValid cycle must match the oldest pending expectation
   always @(negedge clk) begin
      if (OValid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ovalid: got OValid=1 with ALUOut %h expected no result", OALUOut);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mon_memdata",  OMemData,           e.data);
            chk("mon_aluout",   OALUOut,            e.alu);
            chk("mon_writereg", {27'd0, OWriteReg}, {27'd0, e.wreg});
            chk("mon_regwrite", {31'd0, OCRegWrite}, {31'd0, e.rw});
            chk("mon_memtoreg", {30'd0, OCMemtoReg}, {30'd0, e.m2r});
            chk("mon_misalign", {31'd0, OMisalign}, {31'd0, e.mis});
         end
      end
   end

   // Memory access with hand-computed bus and result expectations
   task automatic do_mem(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rd, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] rdata, input int waits,
                         input logic [31:0] exp_data, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_baddr,
                         input logic [4:0] wreg);
      int stalls;
      stalls      = 0;
      IValid      = 1'b1;
      IALUOut     = addr;
      IWriteData  = wdata;
      ICMemRead   = rd;
      ICMemWrite  = wr;
      ICMemSize   = size;
      ICMemSigned = sgn;
      IWriteReg   = wreg;
      ICRegWrite  = 1'b1;
      ICMemtoReg  = 2'b01;
      IBusReady   = 1'b1;
      IBusRData   = 32'hDEADBEEF;
      sb.push_back('{data: exp_data, alu: addr, wreg: wreg, rw: 1'b1, m2r: 2'b01, mis: 1'b0});
      @(negedge clk);
      if (OStall) stalls++;
      chk("idle_busreq", {31'd0, OBusReq}, 32'd0);
      tick();
      for (int i = 0; i <= waits; i++) begin
         IBusReady = (i == waits);
         IBusRData = (i == waits) ? rdata : 32'hDEADBEEF;
         @(negedge clk);
         if (OStall) stalls++;
         chk("wait_busreq", {31'd0, OBusReq}, 32'd1);
         chk("wait_buswe",  {31'd0, OBusWe},  {31'd0, wr});
         chk("wait_busbe",  {28'd0, OBusBe},  {28'd0, exp_be});
         chk("wait_busaddr", OBusAddr, exp_baddr);
         chk("wait_buswdata", OBusWData, exp_wdata);
         tick();
      end
      IValid     = 1'b0;
      IBusReady  = 1'b0;
      ICMemRead  = 1'b0;
      ICMemWrite = 1'b0;
      @(negedge clk);
      chk("latency_ovalid", {31'd0, OValid}, 32'd1);
      chk("done_busreq", {31'd0, OBusReq}, 32'd0);
      chk("stall_cycles", stalls, waits + 1);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; IValid = 1'b0; IALUOut = '0; IWriteData = '0; IWriteReg = '0;
      ICRegWrite = 1'b0; ICMemtoReg = '0; ICMemRead = 1'b0; ICMemWrite = 1'b0;
      ICMemSize = '0; ICMemSigned = 1'b0; IBusRData = '0; IBusReady = 1'b0;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ovalid",  {31'd0, OValid},  32'd0);
      chk("rst_busreq",  {31'd0, OBusReq}, 32'd0);
      chk("rst_stall",   {31'd0, OStall},  32'd0);
      chk("rst_aluout",  OALUOut,  32'd0);
      chk("rst_busaddr", OBusAddr, 32'd0);
      tick();

      // Plain ALU result passes straight through
      IValid = 1'b1; IALUOut = 32'h1234; IWriteReg = 5'd5; ICRegWrite = 1'b1; ICMemtoReg = 2'b00;
      sb.push_back('{data: 32'd0, alu: 32'h1234, wreg: 5'd5, rw: 1'b1, m2r: 2'b00, mis: 1'b0});
      @(negedge clk);
      chk("alu_stall", {31'd0, OStall}, 32'd0);
      tick();
      IValid = 1'b0; IALUOut = 32'h5555; ICRegWrite = 1'b1;
      @(negedge clk);
      chk("alu_ovalid", {31'd0, OValid}, 32'd1);
      tick();
      @(negedge clk);
      chk("bubble_ovalid",   {31'd0, OValid},     32'd0);
      chk("bubble_regwrite", {31'd0, OCRegWrite}, 32'd0);
      chk("bubble_hold_alu", OALUOut, 32'h1234);
      tick();

      do_mem(32'h103, 32'h0, 1, 0, 2'b10, 1, 32'h80FFFFFF, 3, 32'hFFFFFF80, 4'b1000, 32'h0, 32'h100, 5'd7);
      do_mem(32'h202, 32'hABCD1234, 0, 1, 2'b01, 0, 32'h0, 0, 32'h0, 4'b1100, 32'h12341234, 32'h200, 5'd9);
      do_mem(32'h102, 32'h0, 1, 0, 2'b01, 0, 32'h80017FFF, 0, 32'h00008001, 4'b1100, 32'h0, 32'h100, 5'd10);
      do_mem(32'h100, 32'h0, 1, 0, 2'b01, 1, 32'h12348001, 2, 32'hFFFF8001, 4'b0011, 32'h0, 32'h100, 5'd11);
      do_mem(32'h001, 32'h0, 1, 0, 2'b10, 0, 32'h0000A500, 1, 32'h000000A5, 4'b0010, 32'h0, 32'h0, 5'd12);
      do_mem(32'h003, 32'h000000EE, 1, 1, 2'b10, 0, 32'h12345678, 0, 32'h0, 4'b1000, 32'hEEEEEEEE, 32'h0, 5'd13);
      do_mem(32'h010, 32'h11223344, 0, 1, 2'b11, 0, 32'h0, 0, 32'h0, 4'b1111, 32'h11223344, 32'h10, 5'd14);

`ifdef MEM_MISALIGN_TRAP_EN
      IValid = 1'b1; IALUOut = 32'h6; ICMemRead = 1'b1; ICMemSize = 2'b00; IWriteReg = 5'd15;
      ICRegWrite = 1'b1; ICMemtoReg = 2'b01;
      sb.push_back('{data: 32'd0, alu: 32'h6, wreg: 5'd15, rw: 1'b0, m2r: 2'b01, mis: 1'b1});
      @(negedge clk);
      chk("trap_stall", {31'd0, OStall}, 32'd0);
      tick();
      IValid = 1'b0; ICMemRead = 1'b0;
      @(negedge clk);
      chk("trap_busreq", {31'd0, OBusReq}, 32'd0);
      chk("trap_ovalid", {31'd0, OValid},  32'd1);
      tick();
`else
      do_mem(32'h006, 32'h0, 1, 0, 2'b00, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'h4, 5'd15);
`endif

      // Reset during the second WAIT cycle abandons the load
      IValid = 1'b1; IALUOut = 32'h40; ICMemRead = 1'b1; ICMemSize = 2'b00; IWriteReg = 5'd3;
      ICRegWrite = 1'b1; IBusReady = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; IValid = 1'b0; ICMemRead = 1'b0; IBusReady = 1'b1; IBusRData = 32'h77777777;
      @(negedge clk);
      chk("abort_busreq",  {31'd0, OBusReq}, 32'd0);
      chk("abort_ovalid",  {31'd0, OValid},  32'd0);
      chk("abort_memdata", OMemData,  32'd0);
      chk("abort_aluout",  OALUOut,   32'd0);
      chk("abort_busbe",   {28'd0, OBusBe}, 32'd0);
      tick();
      IBusReady = 1'b0;
      @(negedge clk);
      chk("abort_late_ovalid", {31'd0, OValid},  32'd0);
      chk("abort_late_busreq", {31'd0, OBusReq}, 32'd0);
      tick(); tick();
      chk("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
